// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/ready handshake with data memory,
// store lane encoding, load extraction with sign/zero extension.
module mem_stage_lsu #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  EX_MEM_valid,
  input  logic                  EX_MEM_mem_read,
  input  logic                  EX_MEM_mem_write,
  input  logic [2:0]            EX_MEM_funct3,
  input  logic [ADDR_WIDTH-1:0] EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]  EX_MEM_dataB,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0]  dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ready,
  input  logic [REG_WIDTH-1:0]  dmem_rdata,
  output logic [REG_WIDTH-1:0]  DMEM_data_out,
  output logic                  mem_stall,
  output logic                  misaligned_exc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 w_access;
  logic                 w_load;
  logic                 w_illegal;
  logic                 w_misal;
  logic                 w_fault;
  logic                 w_start;
  logic [1:0]           w_lo;
  logic [3:0]           w_be;
  logic [REG_WIDTH-1:0] w_wdata;
  logic [2:0]           r_funct3;
  logic [1:0]           r_lo;
  logic                 r_load;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [REG_WIDTH-1:0] w_ext;

  assign w_access = EX_MEM_valid &
                    (EX_MEM_mem_read | EX_MEM_mem_write);
  assign w_load   = EX_MEM_mem_read;
  assign w_lo     = EX_MEM_alu_out[1:0];

  always_comb begin
    w_illegal = 1'b0;
    if (w_load) begin
      w_illegal = (EX_MEM_funct3 == 3'b011) |
                  (EX_MEM_funct3 == 3'b110) |
                  (EX_MEM_funct3 == 3'b111);
    end else begin
      w_illegal = EX_MEM_funct3[2] |
                  (EX_MEM_funct3[1:0] == 2'b11);
    end
  end

  always_comb begin
    w_misal = 1'b0;
    case (EX_MEM_funct3[1:0])
      2'b01:   w_misal = w_lo[0];
      2'b10:   w_misal = (w_lo != 2'b00);
      default: w_misal = 1'b0;
    endcase
  end

  assign w_fault = w_access & (w_illegal | w_misal);
  assign w_start = w_access & ~w_illegal & ~w_misal;

  assign misaligned_exc = w_fault;

  // Byte enables follow the access size for loads too; memory may ignore them.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = EX_MEM_dataB;
    case (EX_MEM_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{EX_MEM_dataB[7:0]}};
      end
      2'b01: begin
        w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{EX_MEM_dataB[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = EX_MEM_dataB;
      end
    endcase
  end

  assign w_byte = dmem_rdata[8*r_lo +: 8];
  assign w_half = r_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_ext = dmem_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_REQ;
      S_REQ:   if (dmem_ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_stall = ((r_state == S_IDLE) & w_start) |
                     (r_state == S_REQ);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= 4'b0000;
      DMEM_data_out <= '0;
      r_funct3      <= 3'b000;
      r_lo          <= 2'b00;
      r_load        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ~w_load;
            dmem_addr  <= {EX_MEM_alu_out[ADDR_WIDTH-1:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            r_funct3   <= EX_MEM_funct3;
            r_lo       <= w_lo;
            r_load     <= w_load;
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (r_load) DMEM_data_out <= w_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
